// File: rtl/mv_uart_cmd_rx.sv
// UART command receiver: 8N1 bytes parsed into 4-byte frames (0xA5, addr, data, addr+data) that issue config writes.
// Define MV_UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module mv_uart_cmd_rx #(
    parameter int CLK_HZ       = 16000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       cfg_wr,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic       frame_err,
    output logic       chk_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TMO_CLKS     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int BW           = $clog2(CLKS_PER_BIT + 1);
    localparam int TW           = $clog2(TMO_CLKS + 1);

    // Start load is two short: one clock is spent detecting the edge in IDLE and
    // one more because the sample happens on the clock after the count expires.
    localparam logic [BW-1:0] START_LOAD = BW'(HALF_BIT - 2);
    localparam logic [BW-1:0] BIT_LOAD   = BW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(TMO_CLKS);
    localparam logic [7:0]    SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
`ifdef MV_UART_RX_PARITY_EN
        B_PARITY,
`endif
        B_STOP
    } bit_state_t;

    typedef enum logic [1:0] {
        P_SYNC,
        P_ADDR,
        P_DATA,
        P_CHK
    } parse_state_t;

    logic [1:0]   rx_sync;
    logic         rxs;

    bit_state_t   bstate_q, bstate_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    logic [7:0]   shift_q, shift_d;
    logic         rx_ok, rx_bad;
    logic         stop_good;

`ifdef MV_UART_RX_PARITY_EN
    logic         par_err_q, par_err_d;
`endif

    parse_state_t pstate_q, pstate_d;
    logic [7:0]   addr_q, addr_d;
    logic [7:0]   data_q, data_d;
    logic [7:0]   sum;
    logic         wr_d, cerr_d;
    logic [TW-1:0] tmo_cnt_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rxs = rx_sync[1];

`ifdef MV_UART_RX_PARITY_EN
    assign stop_good = rxs && !par_err_q;
`else
    assign stop_good = rxs;
`endif

    always_comb begin
        bstate_d  = bstate_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_ok     = 1'b0;
        rx_bad    = 1'b0;
`ifdef MV_UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (bstate_q)
            B_IDLE: begin
                if (!rxs) begin
                    bstate_d  = B_START;
                    bit_cnt_d = START_LOAD;
                end
            end
            B_START: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end else if (rxs) begin
                    bstate_d = B_IDLE;
                end else begin
                    bstate_d  = B_DATA;
                    bit_cnt_d = BIT_LOAD;
                    bit_idx_d = 3'd0;
                end
            end
            B_DATA: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end else begin
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_cnt_d = BIT_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef MV_UART_RX_PARITY_EN
                        bstate_d = B_PARITY;
`else
                        bstate_d = B_STOP;
`endif
                    end
                end
            end
`ifdef MV_UART_RX_PARITY_EN
            B_PARITY: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end else begin
                    par_err_d = (rxs != ^shift_q);
                    bit_cnt_d = BIT_LOAD;
                    bstate_d  = B_STOP;
                end
            end
`endif
            B_STOP: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end else begin
                    bstate_d = B_IDLE;
                    if (stop_good) begin
                        rx_ok = 1'b1;
                    end else begin
                        rx_bad = 1'b1;
                    end
                end
            end
            default: bstate_d = B_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bstate_q   <= B_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            byte_data  <= 8'h00;
`ifdef MV_UART_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            bstate_q   <= bstate_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            byte_valid <= rx_ok;
            frame_err  <= rx_bad;
            if (rx_ok) begin
                byte_data <= shift_q;
            end
`ifdef MV_UART_RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign sum = addr_q + data_q;

    // Parser: SYNC waits for 0xA5, ADDR/DATA latch payload, CHK verifies the sum byte.
    always_comb begin
        pstate_d = pstate_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_d     = 1'b0;
        cerr_d   = 1'b0;
        if (frame_err) begin
            pstate_d = P_SYNC;
        end else if (byte_valid) begin
            case (pstate_q)
                P_SYNC: begin
                    if (byte_data == SYNC_BYTE) begin
                        pstate_d = P_ADDR;
                    end
                end
                P_ADDR: begin
                    addr_d   = byte_data;
                    pstate_d = P_DATA;
                end
                P_DATA: begin
                    data_d   = byte_data;
                    pstate_d = P_CHK;
                end
                P_CHK: begin
                    if (byte_data == sum) begin
                        wr_d = 1'b1;
                    end else begin
                        cerr_d = 1'b1;
                    end
                    pstate_d = P_SYNC;
                end
                default: pstate_d = P_SYNC;
            endcase
        end else if ((tmo_cnt_q == '0) && (pstate_q != P_SYNC)) begin
            pstate_d = P_SYNC;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pstate_q  <= P_SYNC;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            cfg_wr    <= 1'b0;
            chk_err   <= 1'b0;
            cfg_addr  <= 8'h00;
            cfg_data  <= 8'h00;
            tmo_cnt_q <= '0;
        end else begin
            pstate_q <= pstate_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cfg_wr   <= wr_d;
            chk_err  <= cerr_d;
            if (wr_d) begin
                cfg_addr <= addr_q;
                cfg_data <= data_q;
            end
            // Counter parks at zero; it only matters once a frame is in progress.
            if (byte_valid) begin
                tmo_cnt_q <= TMO_LOAD;
            end else if (tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - TW'(1);
            end
        end
    end

    assign busy = (bstate_q != B_IDLE) || (pstate_q != P_SYNC);

endmodule

// File: tb/tb_mv_uart_cmd_rx.sv
// Testbench for mv_uart_cmd_rx: directed frames plus randomized frames checked against a queue-based frame model.
module tb_mv_uart_cmd_rx;

    localparam int CLK_HZ       = 5000000;
    localparam int BAUD         = 100000;
    localparam int TIMEOUT_BITS = 20;
    localparam int CPB          = CLK_HZ / BAUD;
    localparam int TMO          = TIMEOUT_BITS * CPB;
    localparam int LONG_GAP     = TMO + 300;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rx = 1'b1;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       cfg_wr;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       frame_err;
    logic       chk_err;
    logic       busy;

    always #10 sys_clk = ~sys_clk;

    mv_uart_cmd_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .rx(rx),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .cfg_wr(cfg_wr),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .frame_err(frame_err),
        .chk_err(chk_err),
        .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // observed events
    logic [7:0]  obs_bytes[$];
    logic [15:0] obs_wr[$];
    int          obs_chk = 0;
    int          obs_fe = 0;
    logic        prev_bv = 1'b0;

    always @(negedge sys_clk) begin
        if (byte_valid) begin
            obs_bytes.push_back(byte_data);
            check_val("bv_width", {31'd0, prev_bv}, 32'd0);
        end
        if (byte_valid | frame_err)
            check_val("bv_fe_excl", {31'd0, byte_valid & frame_err}, 32'd0);
        if (cfg_wr | chk_err)
            check_val("wr_cerr_excl", {31'd0, cfg_wr & chk_err}, 32'd0);
        if (cfg_wr) begin
            obs_wr.push_back({cfg_addr, cfg_data});
            check_val("wr_latency", {31'd0, prev_bv}, 32'd1);
        end
        if (chk_err) begin
            obs_chk++;
            check_val("chk_latency", {31'd0, prev_bv}, 32'd1);
        end
        if (frame_err) obs_fe++;
        prev_bv = byte_valid;
    end

    // reference model: a frame is just the queue of bytes collected since the sync byte
    logic [7:0]  mq[$];
    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_wr[$];
    int          exp_chk = 0;
    int          exp_fe = 0;
    logic [7:0]  exp_addr = 8'h00;
    logic [7:0]  exp_data = 8'h00;

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_fe++;
            mq.delete();
        end else begin
            exp_bytes.push_back(b);
            if (mq.size() == 0) begin
                if (b == 8'hA5) mq.push_back(b);
            end else begin
                mq.push_back(b);
                if (mq.size() == 4) begin
                    if (8'(mq[1] + mq[2]) == mq[3]) begin
                        exp_wr.push_back({mq[1], mq[2]});
                        exp_addr = mq[1];
                        exp_data = mq[2];
                    end else begin
                        exp_chk++;
                    end
                    mq.delete();
                end
            end
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int gap);
        int per;
        rx = 1'b1;
        wait_clks(gap);
        if (gap >= TMO) mq.delete();
        // bad-stop bytes use the nominal rate so the forced-low stop cleanly straddles the sample
        per = stop_ok ? int'($urandom_range(CPB + 1, CPB - 1)) : CPB;
        rx = 1'b0;
        wait_clks(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(per);
        end
`ifdef MV_UART_RX_PARITY_EN
        rx = (^b) ^ !par_ok;
        wait_clks(per);
`endif
        if (stop_ok) begin
            rx = 1'b1;
            wait_clks(per);
        end else begin
            rx = 1'b0;
            wait_clks(CPB / 2 + 7);
            rx = 1'b1;
            wait_clks(CPB - (CPB / 2 + 7) + CPB);
        end
        model_byte(b, stop_ok && par_ok);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send(b, 1'b1, 1'b1, int'($urandom_range(0, 8)));
    endtask

    task automatic check_segment(input string tag);
        wait_clks(20);
        check_val({tag, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
        for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++)
            check_val({tag, "_byte"}, {24'd0, obs_bytes[i]}, {24'd0, exp_bytes[i]});
        check_val({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
            check_val({tag, "_wr"}, {16'd0, obs_wr[i]}, {16'd0, exp_wr[i]});
        check_val({tag, "_chk_err"}, obs_chk, exp_chk);
        check_val({tag, "_frame_err"}, obs_fe, exp_fe);
        check_val({tag, "_cfg_addr"}, {24'd0, cfg_addr}, {24'd0, exp_addr});
        check_val({tag, "_cfg_data"}, {24'd0, cfg_data}, {24'd0, exp_data});
        obs_bytes.delete();
        obs_wr.delete();
        exp_bytes.delete();
        exp_wr.delete();
        obs_chk = 0;
        obs_fe = 0;
        exp_chk = 0;
        exp_fe = 0;
    endtask

    initial begin
        logic [7:0] f[4];
        logic [7:0] a, d, rb;
        int kind, pos;

        wait_clks(3);
        check_val("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check_val("rst_byte_data", {24'd0, byte_data}, 32'd0);
        check_val("rst_cfg_wr", {31'd0, cfg_wr}, 32'd0);
        check_val("rst_cfg_addr", {24'd0, cfg_addr}, 32'd0);
        check_val("rst_cfg_data", {24'd0, cfg_data}, 32'd0);
        check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_val("rst_chk_err", {31'd0, chk_err}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        sys_rst = 1'b0;
        wait_clks(5);

        send_ok(8'hA5); send_ok(8'h10); send_ok(8'h3C); send_ok(8'h4C);
        check_segment("good_frame");

        send_ok(8'hA5); send_ok(8'h10); send_ok(8'h3C); send_ok(8'h00);
        check_segment("bad_sum");

        send_ok(8'h00); send_ok(8'hFF);
        send_ok(8'hA5); send_ok(8'hA5); send_ok(8'h01); send_ok(8'hA6);
        check_segment("resync_addr_a5");

        rx = 1'b0;
        wait_clks(20);
        rx = 1'b1;
        wait_clks(3 * CPB);
        check_val("glitch_busy", {31'd0, busy}, 32'd0);
        check_segment("glitch");

        send_ok(8'hA5); send_ok(8'h22);
        send(8'h5A, 1'b0, 1'b1, 3);
        send_ok(8'hA5); send_ok(8'h01); send_ok(8'h02); send_ok(8'h03);
        check_segment("stop_abort");

        send_ok(8'hA5); send_ok(8'h10);
        send(8'h3C, 1'b1, 1'b1, LONG_GAP);
        send_ok(8'h4C);
        check_segment("timeout");

        // reset in the middle of data bit 4
        rx = 1'b0;
        wait_clks(CPB);
        rb = 8'h96;
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            wait_clks(CPB);
        end
        rx = rb[4];
        wait_clks(CPB / 2);
        sys_rst = 1'b1;
        #2;
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_byte_data", {24'd0, byte_data}, 32'd0);
        check_val("mid_rst_cfg_addr", {24'd0, cfg_addr}, 32'd0);
        check_val("mid_rst_cfg_data", {24'd0, cfg_data}, 32'd0);
        check_val("mid_rst_pulses", {29'd0, byte_valid, cfg_wr, frame_err}, 32'd0);
        mq.delete();
        exp_addr = 8'h00;
        exp_data = 8'h00;
        rx = 1'b1;
        wait_clks(2);
        sys_rst = 1'b0;
        wait_clks(2 * CPB);
        send_ok(8'hA5); send_ok(8'h33); send_ok(8'h44); send_ok(8'h77);
        check_segment("after_reset");

`ifdef MV_UART_RX_PARITY_EN
        send(8'h03, 1'b1, 1'b0, 5);
        send_ok(8'hA5); send_ok(8'h03); send_ok(8'h04); send_ok(8'h07);
        check_segment("parity");
`endif

        for (int n = 0; n < 12; n++) begin
            kind = int'($urandom_range(0, 3));
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            f[0] = 8'hA5;
            f[1] = a;
            f[2] = d;
            f[3] = 8'(a + d);
            if (kind == 1) f[3] = f[3] ^ (8'h01 << $urandom_range(0, 7));
            pos = (kind == 3) ? int'($urandom_range(0, 3)) : 4;
            if (kind == 2) begin
                send(8'($urandom_range(0, 255)), 1'b1, 1'b1, int'($urandom_range(0, 40)));
            end else begin
                for (int i = 0; i < 4; i++)
                    send(f[i], (i != pos), 1'b1,
                         ($urandom_range(0, 11) == 0) ? LONG_GAP : int'($urandom_range(0, 40)));
            end
        end
        check_segment("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
